// File: rtl/pc_branch_sequencer.sv
// Program counter owner: sequential fetch, taken-branch redirect with a flush
// window for wrong-path squash, and a terminal halt at the exit address.
module pc_branch_sequencer #(
  parameter logic [7:0] RESET_PC     = 8'h04,
  parameter int         PC_STEP      = 4,
  parameter logic [7:0] EXIT_PC      = 8'h80,
  parameter int         FLUSH_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_stall,
  input  logic       i_br_taken,
  input  logic [7:0] i_br_target,
  output logic [7:0] o_pc,
  output logic       o_fetch_valid,
  output logic       o_flush,
  output logic       o_halted,
  output logic       o_align_err,
  output logic [7:0] o_br_count
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  localparam logic [7:0] STEP       = 8'(PC_STEP);
  localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES);

  state_t     r_state;
  logic [7:0] r_pc;
  logic [2:0] r_flush_cnt;
  logic       r_align_err;
  logic [7:0] r_br_count;

  state_t     w_next_state;
  logic [7:0] w_next_pc;
  logic [2:0] w_next_flush_cnt;
  logic       w_next_align_err;
  logic [7:0] w_next_br_count;
  logic       w_fetch;
  logic       w_aligned;
  logic       w_hit_exit;

  assign w_fetch    = (r_state != ST_HALT) && !i_stall;
  assign w_aligned  = (i_br_target[1:0] == 2'b00);
  assign w_hit_exit = (r_pc == EXIT_PC) && w_fetch;

  always_comb begin
    // NOTE: every target gets its hold value first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    w_next_state     = r_state;
    w_next_pc        = r_pc;
    w_next_flush_cnt = r_flush_cnt;
    w_next_align_err = r_align_err;
    w_next_br_count  = r_br_count;

    unique case (r_state)
      ST_RUN: begin
        if (i_br_taken && w_aligned) begin
          // Redirect beats both the exit check and a stall.
          w_next_pc        = i_br_target;
          w_next_flush_cnt = FLUSH_INIT;
          w_next_state     = ST_FLUSH;
          if (r_br_count != 8'hFF) w_next_br_count = r_br_count + 8'd1;
        end else begin
          if (i_br_taken) w_next_align_err = 1'b1;
          if (w_hit_exit)   w_next_state = ST_HALT;
          else if (w_fetch) w_next_pc    = r_pc + STEP;
        end
      end

      ST_FLUSH: begin
        // Branches seen here come from squashed instructions and are ignored.
        w_next_flush_cnt = r_flush_cnt - 3'd1;
        if (r_flush_cnt == 3'd1) w_next_state = ST_RUN;
        if (w_hit_exit)   w_next_state = ST_HALT;
        else if (w_fetch) w_next_pc    = r_pc + STEP;
      end

      ST_HALT: ;

      default: w_next_state = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      r_state     <= ST_RUN;
      r_pc        <= RESET_PC;
      r_flush_cnt <= 3'd0;
      r_align_err <= 1'b0;
      r_br_count  <= 8'd0;
    end else begin
      r_state     <= w_next_state;
      r_pc        <= w_next_pc;
      r_flush_cnt <= w_next_flush_cnt;
      r_align_err <= w_next_align_err;
      r_br_count  <= w_next_br_count;
    end
  end

  assign o_pc          = r_pc;
  assign o_fetch_valid = !rst && w_fetch;
  assign o_flush       = (r_state == ST_FLUSH);
  assign o_halted      = (r_state == ST_HALT);
  assign o_align_err   = r_align_err;
  assign o_br_count    = r_br_count;

endmodule

// File: tb/tb_pc_branch_sequencer.sv
// Directed-vector bench for pc_branch_sequencer: the driver queues the
// hand-computed outputs for each cycle, a monitor pops and compares them.
module tb_pc_branch_sequencer;

  typedef struct packed {
    logic [7:0] pc;
    logic       fv;
    logic       fl;
    logic       h;
    logic       ae;
    logic [7:0] cnt;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       stall = 1'b0;
  logic       br_taken = 1'b0;
  logic [7:0] br_target = 8'h00;
  logic [7:0] pc;
  logic       fetch_valid;
  logic       flush;
  logic       halted;
  logic       align_err;
  logic [7:0] br_count;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t exp_q[$];
  int   vec_id = 0;

  always #5 clk = ~clk;

  pc_branch_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .i_stall      (stall),
    .i_br_taken   (br_taken),
    .i_br_target  (br_target),
    .o_pc         (pc),
    .o_fetch_valid(fetch_valid),
    .o_flush      (flush),
    .o_halted     (halted),
    .o_align_err  (align_err),
    .o_br_count   (br_count)
  );

  task automatic check(input string name, input int id, input logic [7:0] act, input logic [7:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s (vector %0d): got %h, expected %h", name, id, act, req);
    end
  endtask

  // Drive one cycle of inputs and queue the outputs expected during that cycle.
  task automatic vec(input logic r, input logic s, input logic t, input logic [7:0] tgt,
                     input logic [7:0] e_pc, input logic e_fv, input logic e_fl,
                     input logic e_h, input logic e_ae, input logic [7:0] e_cnt);
    exp_t e;
    @(negedge clk);
    rst = r; stall = s; br_taken = t; br_target = tgt;
    e.pc = e_pc; e.fv = e_fv; e.fl = e_fl; e.h = e_h; e.ae = e_ae; e.cnt = e_cnt;
    exp_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    int   id;
    id = 0;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("pc",          id, pc,                 e.pc);
        check("fetch_valid", id, {7'd0, fetch_valid}, {7'd0, e.fv});
        check("flush",       id, {7'd0, flush},       {7'd0, e.fl});
        check("halted",      id, {7'd0, halted},      {7'd0, e.h});
        check("align_err",   id, {7'd0, align_err},   {7'd0, e.ae});
        check("br_count",    id, br_count,            e.cnt);
        id++;
      end
    end
  end

  initial begin : stimulus
    int budget;
    repeat (2) @(posedge clk);
    //   rst stall tkn tgt    pc    fv fl h ae cnt
    vec(1, 0, 0, 8'h00, 8'h04, 0, 0, 0, 0, 8'd0);  // reset state
    // sequential fetch from RESET_PC
    vec(0, 0, 0, 8'h00, 8'h04, 1, 0, 0, 0, 8'd0);
    vec(0, 0, 0, 8'h00, 8'h08, 1, 0, 0, 0, 8'd0);
    vec(0, 0, 0, 8'h00, 8'h0C, 1, 0, 0, 0, 8'd0);
    // taken branch to 38, wrong-path branch to 50 ignored during flush
    vec(0, 0, 1, 8'h38, 8'h10, 1, 0, 0, 0, 8'd0);
    vec(0, 0, 1, 8'h50, 8'h38, 1, 1, 0, 0, 8'd1);
    vec(0, 0, 0, 8'h00, 8'h3C, 1, 1, 0, 0, 8'd1);
    vec(0, 0, 0, 8'h00, 8'h40, 1, 0, 0, 0, 8'd1);
    // branch to 14, then stall 3 cycles (flush counter keeps running)
    vec(0, 0, 1, 8'h14, 8'h44, 1, 0, 0, 0, 8'd1);
    vec(0, 1, 0, 8'h00, 8'h14, 0, 1, 0, 0, 8'd2);
    vec(0, 1, 0, 8'h00, 8'h14, 0, 1, 0, 0, 8'd2);
    vec(0, 1, 0, 8'h00, 8'h14, 0, 0, 0, 0, 8'd2);
    vec(0, 0, 0, 8'h00, 8'h14, 1, 0, 0, 0, 8'd2);
    // redirect taken while stalled
    vec(0, 1, 1, 8'h70, 8'h18, 0, 0, 0, 0, 8'd2);
    vec(0, 0, 0, 8'h00, 8'h70, 1, 1, 0, 0, 8'd3);
    vec(0, 0, 0, 8'h00, 8'h74, 1, 1, 0, 0, 8'd3);
    vec(0, 0, 0, 8'h00, 8'h78, 1, 0, 0, 0, 8'd3);
    vec(0, 0, 0, 8'h00, 8'h7C, 1, 0, 0, 0, 8'd3);
    // redirect at the exit address wins over halt
    vec(0, 0, 1, 8'h20, 8'h80, 1, 0, 0, 0, 8'd3);
    vec(0, 0, 0, 8'h00, 8'h20, 1, 1, 0, 0, 8'd4);
    vec(0, 0, 0, 8'h00, 8'h24, 1, 1, 0, 0, 8'd4);
    // misaligned target dropped, align_err sticky
    vec(0, 0, 1, 8'h3A, 8'h28, 1, 0, 0, 0, 8'd4);
    vec(0, 0, 0, 8'h00, 8'h2C, 1, 0, 0, 1, 8'd4);
    // reach exit through a flush window, then halt ignores inputs
    vec(0, 0, 1, 8'h7C, 8'h30, 1, 0, 0, 1, 8'd4);
    vec(0, 0, 0, 8'h00, 8'h7C, 1, 1, 0, 1, 8'd5);
    vec(0, 0, 0, 8'h00, 8'h80, 1, 1, 0, 1, 8'd5);
    vec(0, 0, 1, 8'h40, 8'h80, 0, 0, 1, 1, 8'd5);
    vec(0, 0, 0, 8'h00, 8'h80, 0, 0, 1, 1, 8'd5);
    // reset out of halt
    vec(1, 0, 0, 8'h00, 8'h80, 0, 0, 1, 1, 8'd5);
    vec(0, 0, 0, 8'h00, 8'h04, 1, 0, 0, 0, 8'd0);
    // reset in the middle of a flush window
    vec(0, 0, 1, 8'h40, 8'h08, 1, 0, 0, 0, 8'd0);
    vec(1, 0, 0, 8'h00, 8'h40, 0, 1, 0, 0, 8'd1);
    vec(0, 0, 0, 8'h00, 8'h04, 1, 0, 0, 0, 8'd0);
    // target equal to current pc reloads and opens a flush window
    vec(0, 0, 1, 8'h08, 8'h08, 1, 0, 0, 0, 8'd0);
    vec(0, 0, 0, 8'h00, 8'h08, 1, 1, 0, 0, 8'd1);
    vec(0, 0, 0, 8'h00, 8'h0C, 1, 1, 0, 0, 8'd1);
    // pc wraps modulo 256
    vec(0, 0, 1, 8'hFC, 8'h10, 1, 0, 0, 0, 8'd1);
    vec(0, 0, 0, 8'h00, 8'hFC, 1, 1, 0, 0, 8'd2);
    vec(0, 0, 0, 8'h00, 8'h00, 1, 1, 0, 0, 8'd2);
    vec(0, 0, 0, 8'h00, 8'h04, 1, 0, 0, 0, 8'd2);

    budget = 20;
    while (exp_q.size() != 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    #5;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
